matmul_job_controller: RTL and testbench
========================================

Name: matmul_job_controller

Overview:
Sequences one N×N matrix multiply job on the systolic multiplier. Accepts a command holding three buffer addresses, fetches A and B rows from the unified buffer, and holds the array in reset while loading. It then releases the array for the fixed compute window, drains the N accumulator rows back to the buffer under backpressure, and pulses done. It sits between the command queue / host interface and the systolic multiplier instance.

Parameters:
N, 2, matrix dimension (rows = cols), 2..256
OP_WIDTH, 8, operand element width
ACC_WIDTH, 32, accumulator element width
ADDR_W, 16, buffer address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd_a_addr  in  ADDR_W  base address of A; row i is at base+i
cmd_b_addr  in  ADDR_W  base address of B; row i is at base+i
cmd_c_addr  in  ADDR_W  base address of result C; row i is written to base+i
rd_en  out  1  buffer read strobe
rd_addr  out  ADDR_W  buffer read address
rd_data  in  N*OP_WIDTH  read data, valid 1 cycle after rd_en; element j at [OP_WIDTH*j +: OP_WIDTH]
arr_reset  out  1  drives the multiplier reset
arr_a  out  N*N*OP_WIDTH  flat row-major A; element (i,j) at [OP_WIDTH*(i*N+j) +: OP_WIDTH]
arr_b  out  N*N*OP_WIDTH  flat row-major B, same packing as arr_a
acc_row_sel  out  clog2(N)  selects the accumulator row being read
acc_row_data  in  N*ACC_WIDTH  selected accumulator row, combinational from the array
wr_valid  out  1  result row write request
wr_ready  in  1  buffer accepts the write
wr_addr  out  ADDR_W  result write address
wr_data  out  N*ACC_WIDTH  result row; equals acc_row_data
busy  out  1  high when the controller is not in IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset values: state = IDLE; cmd_ready = 1; rd_en = 0; wr_valid = 0; arr_reset = 1; arr_a = 0; arr_b = 0; acc_row_sel = 0; busy = 0; done = 0; all counters 0.
- cmd_ready = (state == IDLE). A command is accepted on a cycle where cmd_valid && cmd_ready. On acceptance, latch all three addresses and go to LOAD.
- LOAD:
  - Issue 2N consecutive reads, one per cycle: A rows 0..N-1, then B rows 0..N-1.
  - Capture rd_data one cycle after each issue into row k of the arr_a / arr_b registers.
  - LOAD lasts exactly 2N+1 cycles; the last cycle captures only. Then go to RUN.
  - Address arithmetic is modulo 2^ADDR_W, so base+i wraps.
- arr_reset = 1 in IDLE and LOAD; 0 in RUN and DRAIN.
- arr_a and arr_b are held stable from the end of LOAD until the next command's LOAD begins.
- RUN: count 3N cycles with arr_reset = 0. By then the array state has reached 3N-1 and the accumulators are final. Then go to DRAIN with row = 0.
- DRAIN:
  - wr_valid = 1, acc_row_sel = row, wr_addr = c_addr + row, wr_data = acc_row_data.
  - row increments on each wr_valid && wr_ready.
  - wr_addr, wr_data and acc_row_sel are held stable while wr_ready = 0.
  - After the handshake for row N-1, go to IDLE and assert done = 1 in that first IDLE cycle.
  - The first IDLE cycle may also accept a new command.
- busy = (state != IDLE).
- Nominal latency, with no backpressure, from the acceptance edge to the done pulse: (2N+1) + 3N + N + 1 cycles. For N = 2 this is 14 cycles.
- cmd_valid is ignored outside IDLE; no command is ever lost or duplicated.
- Reset asserted mid-job: return to IDLE at the next edge with reset values; no done pulse and no further writes.
- State counters are sized to clog2(3N+1) bits or wider; they must never wrap within a job.

Optional Feature:
PERF_COUNTERS_EN
- Defined: adds outputs perf_jobs (32 bits) and perf_stall (32 bits).
  - perf_jobs increments on each done pulse.
  - perf_stall increments on every DRAIN cycle with wr_ready = 0.
  - Both saturate at all-ones and clear on reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package matmul_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DRAIN)
  - the RUN_CYCLES = 3*N and LOAD_CYCLES = 2*N+1 functions/constants
  - element packing index helpers shared with the multiplier
- Sub-module matmul_tile_loader: owns the LOAD read issue/capture pipeline and the arr_a/arr_b registers, and signals load_done.

Test Plan:
- N=2, A=[[1,2],[3,4]] at 0x10, B=[[5,6],[7,8]] at 0x20, C base 0x30, wr_ready=1 -> writes 0x30={19,22}, 0x31={43,50}; done pulses 14 cycles after acceptance.
- Same job with wr_ready held low for 3 cycles at row 0 -> wr_addr and wr_data stable throughout the stall; done is delayed by exactly 3 cycles; perf_stall=3 if PERF_COUNTERS_EN.
- cmd_valid held high continuously for two jobs -> second command accepted in the same cycle as the first done pulse; cmd_ready=0 while busy; exactly 4 writes total.
- A base 0xFFFF with ADDR_W=16 -> A row reads at 0xFFFF then 0x0000; results correct.
- Reset asserted during RUN -> next cycle: state IDLE, arr_reset=1, wr_valid=0; no done pulse; a fresh job then completes correctly.
- cmd_valid pulsed during DRAIN -> ignored; no extra reads issued.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul job controller and the systolic multiplier:
// controller state encoding, phase lengths and flat-matrix packing helpers.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // LOAD issues 2N reads and needs one extra cycle to capture the last one.
  function automatic int unsigned load_cycles(input int unsigned n);
    return 2 * n + 1;
  endfunction

  // Cycles the array is released before its accumulators are final.
  function automatic int unsigned run_cycles(input int unsigned n);
    return 3 * n;
  endfunction

  // Bit offset of element (i,j) in a flat row-major n x n matrix of w-bit elements.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                           input int unsigned n, input int unsigned w);
    return w * (i * n + j);
  endfunction

endpackage

// File: rtl/matmul_tile_loader.sv
// Tile loader: while load_active, issues 2N buffer reads (A rows then B rows)
// and captures each returned row one cycle later into the flat arr_a / arr_b
// registers. load_done marks the final, capture-only cycle of LOAD.
module matmul_tile_loader
  import matmul_pkg::*;
#(
  parameter int N        = 2,
  parameter int OP_WIDTH = 8,
  parameter int ADDR_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_active,
  input  logic [ADDR_W-1:0]         a_base,
  input  logic [ADDR_W-1:0]         b_base,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [N*OP_WIDTH-1:0]     rd_data,
  output logic [N*N*OP_WIDTH-1:0]   arr_a,
  output logic [N*N*OP_WIDTH-1:0]   arr_b,
  output logic                      load_done
);

  localparam int CNT_W = $clog2(3 * N + 1);
  localparam int ROW_W = N * OP_WIDTH;
  localparam logic [CNT_W-1:0] READS     = CNT_W'(2 * N);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(load_cycles(N) - 1);
  localparam logic [CNT_W-1:0] N_CNT     = CNT_W'(N);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cap_row_q, cap_row_d;
  logic                    cap_valid_q, cap_valid_d;
  logic [N*N*OP_WIDTH-1:0] arr_a_q, arr_a_d;
  logic [N*N*OP_WIDTH-1:0] arr_b_q, arr_b_d;
  logic [N-1:0]            a_row_we;
  logic [N-1:0]            b_row_we;

  assign rd_en     = load_active && (cnt_q < READS);
  assign load_done = load_active && (cnt_q == LOAD_LAST);
  // Read index 0..N-1 addresses A rows, N..2N-1 addresses B rows; sums wrap mod 2^ADDR_W.
  assign rd_addr   = (cnt_q < N_CNT) ? a_base + ADDR_W'(cnt_q)
                                     : b_base + ADDR_W'(cnt_q - N_CNT);
  assign arr_a     = arr_a_q;
  assign arr_b     = arr_b_q;

  // Per-row write enables for the capture stage.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row_we
      assign a_row_we[gi] = cap_valid_q && (cap_row_q == CNT_W'(gi));
      assign b_row_we[gi] = cap_valid_q && (cap_row_q == CNT_W'(gi + N));
    end
  endgenerate

  // Next-state: advance read counter, pipeline read index, capture returned row.
  always_comb begin
    cnt_d       = (load_active && !load_done) ? cnt_q + CNT_W'(1) : '0;
    cap_valid_d = rd_en;
    cap_row_d   = cnt_q;
    arr_a_d     = arr_a_q;
    arr_b_d     = arr_b_q;
    for (int i = 0; i < N; i++) begin
      if (a_row_we[i]) arr_a_d[elem_lsb(i, 0, N, OP_WIDTH) +: ROW_W] = rd_data;
      if (b_row_we[i]) arr_b_d[elem_lsb(i, 0, N, OP_WIDTH) +: ROW_W] = rd_data;
    end
  end

  // Loader registers; matrices hold their contents until the next capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      cap_row_q   <= '0;
      cap_valid_q <= 1'b0;
      arr_a_q     <= '0;
      arr_b_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      cap_row_q   <= cap_row_d;
      cap_valid_q <= cap_valid_d;
      arr_a_q     <= arr_a_d;
      arr_b_q     <= arr_b_d;
    end
  end

endmodule

// File: rtl/matmul_job_controller.sv
// Matmul job controller: accepts a command with A/B/C base addresses, loads
// the tiles (array held in reset), releases the array for the compute window,
// drains N accumulator rows to the buffer under backpressure, pulses done.
// Optional build macro: PERF_COUNTERS_EN adds perf_jobs / perf_stall outputs.
module matmul_job_controller
  import matmul_pkg::*;
#(
  parameter int N         = 2,
  parameter int OP_WIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int ADDR_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ADDR_W-1:0]           cmd_a_addr,
  input  logic [ADDR_W-1:0]           cmd_b_addr,
  input  logic [ADDR_W-1:0]           cmd_c_addr,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [N*OP_WIDTH-1:0]       rd_data,
  output logic                        arr_reset,
  output logic [N*N*OP_WIDTH-1:0]     arr_a,
  output logic [N*N*OP_WIDTH-1:0]     arr_b,
  output logic [$clog2(N)-1:0]        acc_row_sel,
  input  logic [N*ACC_WIDTH-1:0]      acc_row_data,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [N*ACC_WIDTH-1:0]      wr_data,
  output logic                        busy,
  output logic                        done
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]                 perf_jobs,
  output logic [31:0]                 perf_stall
`endif
);

  localparam int CNT_W = $clog2(3 * N + 1);
  localparam int SEL_W = $clog2(N);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(run_cycles(N) - 1);
  localparam logic [SEL_W-1:0] ROW_LAST = SEL_W'(N - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic [SEL_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
  logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
  logic [ADDR_W-1:0]   c_addr_q, c_addr_d;
  logic                done_q, done_d;
  logic                load_done;
  logic                wr_fire;

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign arr_reset   = (state_q == IDLE) || (state_q == LOAD);
  assign wr_valid    = (state_q == DRAIN);
  assign wr_fire     = wr_valid && wr_ready;
  assign acc_row_sel = row_q;
  assign wr_addr     = c_addr_q + ADDR_W'(row_q);
  assign wr_data     = acc_row_data;
  assign done        = done_q;

  matmul_tile_loader #(
    .N        (N),
    .OP_WIDTH (OP_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_loader (
    .clk         (clk),
    .reset       (reset),
    .load_active (state_q == LOAD),
    .a_base      (a_addr_q),
    .b_base      (b_addr_q),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .arr_a       (arr_a),
    .arr_b       (arr_b),
    .load_done   (load_done)
  );

  // Job sequencing: IDLE -> LOAD -> RUN -> DRAIN -> IDLE (with done pulse).
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    row_d     = row_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    c_addr_d  = c_addr_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_addr_d = cmd_a_addr;
          b_addr_d = cmd_b_addr;
          c_addr_d = cmd_c_addr;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (load_done) begin
          run_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          run_cnt_d = '0;
          row_d     = '0;
          state_d   = DRAIN;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (wr_fire) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
      row_q     <= '0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      c_addr_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      row_q     <= row_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      c_addr_q  <= c_addr_d;
      done_q    <= done_d;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;

  // Saturating job and drain-stall counters.
  always_comb begin
    perf_jobs_d  = perf_jobs_q;
    perf_stall_d = perf_stall_q;
    if (done_q && (perf_jobs_q != '1)) perf_jobs_d = perf_jobs_q + 32'd1;
    if ((state_q == DRAIN) && !wr_ready && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_jobs_q  <= perf_jobs_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_job_controller.sv
// Directed testbench for matmul_job_controller (N=2): buffer and array models,
// one task per scenario with inline comparisons against hand-computed values.
module tb_matmul_job_controller;

  localparam int N   = 2;
  localparam int OP  = 8;
  localparam int ACC = 32;
  localparam int AW  = 16;

  // A=[[1,2],[3,4]] B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]
  localparam logic [N*ACC-1:0] C_ROW0 = {32'd22, 32'd19};
  localparam logic [N*ACC-1:0] C_ROW1 = {32'd50, 32'd43};

  logic                 clk;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [AW-1:0]        cmd_a_addr, cmd_b_addr, cmd_c_addr;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [N*OP-1:0]      rd_data;
  logic                 arr_reset;
  logic [N*N*OP-1:0]    arr_a, arr_b;
  logic [$clog2(N)-1:0] acc_row_sel;
  logic [N*ACC-1:0]     acc_row_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [AW-1:0]        wr_addr;
  logic [N*ACC-1:0]     wr_data;
  logic                 busy;
  logic                 done;
`ifdef PERF_COUNTERS_EN
  logic [31:0]          perf_jobs, perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  logic [N*OP-1:0]  mem [0:65535];
  logic [7:0]       cyc_q;
  logic [AW-1:0]    rd_log[$];
  logic [AW-1:0]    wa_log[$];
  logic [N*ACC-1:0] wd_log[$];
  int               done_cnt;

  matmul_job_controller #(.N(N), .OP_WIDTH(OP), .ACC_WIDTH(ACC), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a_addr   (cmd_a_addr),
    .cmd_b_addr   (cmd_b_addr),
    .cmd_c_addr   (cmd_c_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .arr_reset    (arr_reset),
    .arr_a        (arr_a),
    .arr_b        (arr_b),
    .acc_row_sel  (acc_row_sel),
    .acc_row_data (acc_row_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
`ifdef PERF_COUNTERS_EN
    .perf_jobs    (perf_jobs),
    .perf_stall   (perf_stall),
`endif
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: registered read, data valid one cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Array model: counts released cycles; accumulators are only final after 3N-1.
  always @(posedge clk) begin
    if (arr_reset) cyc_q <= 8'd0;
    else if (cyc_q != 8'hFF) cyc_q <= cyc_q + 8'd1;
  end

  function automatic logic [N*ACC-1:0] model_row(input logic [N*N*OP-1:0] a,
                                                 input logic [N*N*OP-1:0] b, input int s);
    logic [N*ACC-1:0] r;
    logic [ACC-1:0]   sum;
    r = '0;
    for (int j = 0; j < N; j++) begin
      sum = '0;
      for (int k = 0; k < N; k++)
        sum = sum + ACC'(a[OP*(s*N+k) +: OP]) * ACC'(b[OP*(k*N+j) +: OP]);
      r[ACC*j +: ACC] = sum;
    end
    return r;
  endfunction

  assign acc_row_data = (cyc_q >= 8'(3*N-1)) ? model_row(arr_a, arr_b, int'(acc_row_sel)) : '0;

  // Transaction monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_en) rd_log.push_back(rd_addr);
    if (wr_valid && wr_ready) begin
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
      $display("[%0t] write addr=%04h data=%016h", $time, wr_addr, wr_data);
    end
    if (done) begin
      done_cnt++;
      $display("[%0t] job done", $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    done_cnt = 0;
  endtask

  task automatic load_mats(input logic [AW-1:0] a_base, input logic [AW-1:0] b_base);
    logic [AW-1:0] a1, b1;
    a1 = a_base + 16'd1;
    b1 = b_base + 16'd1;
    mem[a_base] = 16'h0201;
    mem[a1]     = 16'h0403;
    mem[b_base] = 16'h0605;
    mem[b1]     = 16'h0807;
  endtask

  // Offers a command in IDLE; returns #1 after the acceptance edge.
  task automatic start_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    cmd_a_addr = a;
    cmd_b_addr = b;
    cmd_c_addr = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts edges from the acceptance edge (=1) until done is seen; flags bad busy/ready.
  task automatic wait_done(output int lat, output bit bad);
    lat = 1;
    bad = 1'b0;
    while (!done && lat < 200) begin
      if (!busy || cmd_ready) bad = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    wr_ready = 1'b1;
    cmd_a_addr = '0; cmd_b_addr = '0; cmd_c_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
    checks++; if (arr_reset !== 1'b1) begin errors++; $display("FAIL reset_arr_reset: got %b want 1", arr_reset); end
    checks++; if (arr_a !== '0) begin errors++; $display("FAIL reset_arr_a: got %h want 0", arr_a); end
    checks++; if (arr_b !== '0) begin errors++; $display("FAIL reset_arr_b: got %h want 0", arr_b); end
    checks++; if (acc_row_sel !== '0) begin errors++; $display("FAIL reset_acc_row_sel: got %h want 0", acc_row_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef PERF_COUNTERS_EN
    checks++; if (perf_jobs !== 32'd0) begin errors++; $display("FAIL reset_perf_jobs: got %0d want 0", perf_jobs); end
    checks++; if (perf_stall !== 32'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d want 0", perf_stall); end
`endif
    #1 reset = 1'b0;
  endtask

  task automatic test_basic_job();
    int lat;
    bit bad;
    do_reset();
    load_mats(16'h0010, 16'h0020);
    start_cmd(16'h0010, 16'h0020, 16'h0030);
    wait_done(lat, bad);
    $display("basic job latency=%0d", lat);
    checks++; if (lat !== 14) begin errors++; $display("FAIL basic_latency: got %0d want 14", lat); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got bad=%b want 0", bad); end
    checks++; if (rd_log.size() !== 4) begin errors++; $display("FAIL basic_read_count: got %0d want 4", rd_log.size()); end
    checks++; if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== 64'h0010_0011_0020_0021) begin
      errors++; $display("FAIL basic_read_addrs: got %h %h %h %h want 0010 0011 0020 0021", rd_log[0], rd_log[1], rd_log[2], rd_log[3]); end
    checks++; if (wa_log.size() !== 2) begin errors++; $display("FAIL basic_write_count: got %0d want 2", wa_log.size()); end
    checks++; if (wa_log[0] !== 16'h0030 || wd_log[0] !== C_ROW0) begin
      errors++; $display("FAIL basic_write0: got %h/%h want 0030/%h", wa_log[0], wd_log[0], C_ROW0); end
    checks++; if (wa_log[1] !== 16'h0031 || wd_log[1] !== C_ROW1) begin
      errors++; $display("FAIL basic_write1: got %h/%h want 0031/%h", wa_log[1], wd_log[1], C_ROW1); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
`ifdef PERF_COUNTERS_EN
    checks++; if (perf_jobs !== 32'd1) begin errors++; $display("FAIL basic_perf_jobs: got %0d want 1", perf_jobs); end
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    int stalls;
    bit bad_stable;
    do_reset();
    load_mats(16'h0010, 16'h0020);
    wr_ready = 1'b0;
    start_cmd(16'h0010, 16'h0020, 16'h0030);
    lat = 1;
    stalls = 0;
    bad_stable = 1'b0;
    while (!done && lat < 200) begin
      if (wr_valid && stalls < 3) begin
        stalls++;
        if (wr_addr !== 16'h0030 || wr_data !== C_ROW0 || acc_row_sel !== 1'b0) bad_stable = 1'b1;
      end else if (wr_valid) begin
        wr_ready = 1'b1;
      end
      @(posedge clk);
      #1 lat++;
    end
    wr_ready = 1'b1;
    $display("backpressure job latency=%0d stalls=%0d", lat, stalls);
    checks++; if (lat !== 17) begin errors++; $display("FAIL bp_latency: got %0d want 17", lat); end
    checks++; if (stalls !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 3", stalls); end
    checks++; if (bad_stable !== 1'b0) begin errors++; $display("FAIL bp_hold_stable: got unstable=%b want 0", bad_stable); end
    checks++; if (wa_log.size() !== 2 || wd_log[0] !== C_ROW0 || wd_log[1] !== C_ROW1 || wa_log[1] !== 16'h0031) begin
      errors++; $display("FAIL bp_writes: got n=%0d %h %h want 2 %h %h", wa_log.size(), wd_log[0], wd_log[1], C_ROW0, C_ROW1); end
`ifdef PERF_COUNTERS_EN
    checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL bp_perf_stall: got %0d want 3", perf_stall); end
    checks++; if (perf_jobs !== 32'd1) begin errors++; $display("FAIL bp_perf_jobs: got %0d want 1", perf_jobs); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    bit bad1, bad2;
    do_reset();
    load_mats(16'h0010, 16'h0020);
    cmd_a_addr = 16'h0010;
    cmd_b_addr = 16'h0020;
    cmd_c_addr = 16'h0030;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat1, bad1);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done: got %b want 1", cmd_ready); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
    wait_done(lat2, bad2);
    cmd_valid = 1'b0;
    $display("back-to-back latencies=%0d,%0d", lat1, lat2);
    checks++; if (lat1 !== 14 || lat2 !== 14) begin errors++; $display("FAIL b2b_latency: got %0d,%0d want 14,14", lat1, lat2); end
    checks++; if (bad1 !== 1'b0 || bad2 !== 1'b0) begin errors++; $display("FAIL b2b_ready_low_busy: got %b%b want 00", bad1, bad2); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third: got busy=%b want 0", busy); end
    checks++; if (wa_log.size() !== 4 || done_cnt !== 2) begin
      errors++; $display("FAIL b2b_counts: got writes=%0d dones=%0d want 4 2", wa_log.size(), done_cnt); end
    checks++; if (wa_log[2] !== 16'h0030 || wd_log[3] !== C_ROW1) begin
      errors++; $display("FAIL b2b_second_writes: got %h/%h want 0030/%h", wa_log[2], wd_log[3], C_ROW1); end
  endtask

  task automatic test_addr_wrap();
    int lat;
    bit bad;
    do_reset();
    load_mats(16'hFFFF, 16'h0020);
    start_cmd(16'hFFFF, 16'h0020, 16'h0040);
    wait_done(lat, bad);
    $display("wrap job latency=%0d", lat);
    checks++; if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== 64'hFFFF_0000_0020_0021) begin
      errors++; $display("FAIL wrap_read_addrs: got %h %h %h %h want ffff 0000 0020 0021", rd_log[0], rd_log[1], rd_log[2], rd_log[3]); end
    checks++; if (wa_log[0] !== 16'h0040 || wd_log[0] !== C_ROW0 || wa_log[1] !== 16'h0041 || wd_log[1] !== C_ROW1) begin
      errors++; $display("FAIL wrap_writes: got %h/%h %h/%h want 0040/%h 0041/%h", wa_log[0], wd_log[0], wa_log[1], wd_log[1], C_ROW0, C_ROW1); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int lat;
    bit bad;
    do_reset();
    load_mats(16'h0010, 16'h0020);
    start_cmd(16'h0010, 16'h0020, 16'h0030);
    n = 0;
    while (arr_reset && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_idle: got busy=%b ready=%b want 0 1", busy, cmd_ready); end
    checks++; if (arr_reset !== 1'b1 || wr_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got arr_reset=%b wr_valid=%b want 1 0", arr_reset, wr_valid); end
    checks++; if (arr_a !== '0) begin errors++; $display("FAIL midrst_arr_a: got %h want 0", arr_a); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt !== 0 || wa_log.size() !== 0) begin
      errors++; $display("FAIL midrst_quiet: got dones=%0d writes=%0d want 0 0", done_cnt, wa_log.size()); end
    start_cmd(16'h0010, 16'h0020, 16'h0030);
    wait_done(lat, bad);
    $display("post-reset job latency=%0d", lat);
    checks++; if (lat !== 14 || wa_log.size() !== 2 || wd_log[0] !== C_ROW0 || wd_log[1] !== C_ROW1) begin
      errors++; $display("FAIL midrst_fresh_job: got lat=%0d n=%0d %h %h want 14 2 %h %h", lat, wa_log.size(), wd_log[0], wd_log[1], C_ROW0, C_ROW1); end
  endtask

  task automatic test_cmd_in_drain();
    int n;
    do_reset();
    load_mats(16'h0010, 16'h0020);
    start_cmd(16'h0010, 16'h0020, 16'h0030);
    n = 0;
    while (!wr_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    cmd_a_addr = 16'h0050;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rd_log.size() !== 4) begin errors++; $display("FAIL drain_cmd_reads: got %0d want 4", rd_log.size()); end
    checks++; if (done_cnt !== 1 || wa_log.size() !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL drain_cmd_ignored: got dones=%0d writes=%0d busy=%b want 1 2 0", done_cnt, wa_log.size(), busy); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    done_cnt = 0;
    test_reset();
    test_basic_job();
    test_backpressure();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid_run();
    test_cmd_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
